// File: rtl/encoder_pkg.sv
// Shared constants for the request encoder: selection mode encoding and a width helper.
package encoder_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width that stays at least one bit wide, so that N=1 corner builds still elaborate.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_scan.sv
// Combinational circular scan: finds the first set request at or above start, wrapping N-1 -> 0.
module rr_scan
    import encoder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        int pos;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            // Explicit wrap keeps non-power-of-two N from walking past N-1.
            pos = int'(start) + k;
            if (pos >= N) pos = pos - N;
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = W'(pos);
            end
        end
    end

endmodule

// File: rtl/priority_encoder_rr.sv
// N-to-log2(N) request encoder with registered outputs, valid/ack hold and fixed or round-robin selection.
module priority_encoder_rr
    import encoder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         mode,
    input  logic [N-1:0] Y,
    input  logic         ack,
    output logic [W-1:0] A,
    output logic         valid,
    output logic         multi
);

    logic [W-1:0] ptr;
    logic [W-1:0] a_inc;
    logic [W-1:0] ptr_eff;
    logic         accept;
    logic         sample;

    logic [N-1:0] y_rev;
    logic [W-1:0] rr_idx;
    logic [W-1:0] rev_idx;
    logic [W-1:0] fx_idx;
    logic         rr_found;
    logic         fx_found;

    logic [W-1:0] win_idx;
    logic         win_found;
    logic         many;

    assign accept  = valid && ack;
    assign sample  = !valid || ack;
    assign a_inc   = (A == W'(N - 1)) ? '0 : A + W'(1);
    // An accept in the same cycle as a sample advances the scan start immediately (no bubble).
    assign ptr_eff = accept ? a_inc : ptr;

    always_comb begin
        y_rev = '0;
        for (int i = 0; i < N; i++) y_rev[i] = Y[N-1-i];
    end

    rr_scan #(.N(N)) u_rr_scan (
        .req   (Y),
        .start (ptr_eff),
        .idx   (rr_idx),
        .found (rr_found)
    );

    // Highest set bit: lowest set bit of the reversed vector, mapped back.
    rr_scan #(.N(N)) u_fx_scan (
        .req   (y_rev),
        .start ('0),
        .idx   (rev_idx),
        .found (fx_found)
    );

    assign fx_idx    = W'(N - 1) - rev_idx;
    assign win_idx   = (mode == MODE_RR) ? rr_idx : fx_idx;
    assign win_found = (mode == MODE_RR) ? rr_found : fx_found;
    assign many      = (Y & (Y - N'(1))) != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            A     <= '0;
            valid <= 1'b0;
            multi <= 1'b0;
            ptr   <= '0;
        end else begin
            if (accept) ptr <= a_inc;
            if (sample) begin
                if (en && win_found) begin
                    A     <= win_idx;
                    valid <= 1'b1;
                    multi <= many;
                end else begin
                    valid <= 1'b0;
                    multi <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Directed bench for priority_encoder_rr: N=4 vector table plus an N=5 round-robin wrap sequence.
module tb_priority_encoder_rr;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       mode;
        logic       ack;
        logic [3:0] y;
        logic       valid_e;
        logic [1:0] a_e;
        logic       multi_e;
    } vec_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, en4, mode4, ack4;
    logic [3:0] y4;
    logic [1:0] a4;
    logic       valid4, multi4;

    logic       rst5, en5, mode5, ack5;
    logic [4:0] y5;
    logic [2:0] a5;
    logic       valid5, multi5;

    int total  = 0;
    int passed = 0;

    priority_encoder_rr #(.N(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst4),
        .en    (en4),
        .mode  (mode4),
        .Y     (y4),
        .ack   (ack4),
        .A     (a4),
        .valid (valid4),
        .multi (multi4)
    );

    priority_encoder_rr #(.N(5)) u_dut5 (
        .clk   (clk),
        .rst   (rst5),
        .en    (en5),
        .mode  (mode5),
        .Y     (y5),
        .ack   (ack5),
        .A     (a5),
        .valid (valid5),
        .multi (multi5)
    );

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    // Inputs applied before an edge, expected outputs right after it.
    task automatic add(input logic r, input logic e, input logic m, input logic k, input logic [3:0] y,
                       input logic v, input logic [1:0] a, input logic mu);
        vec_t t;
        t = '{rst: r, en: e, mode: m, ack: k, y: y, valid_e: v, a_e: a, multi_e: mu};
        vecs.push_back(t);
    endtask

    initial begin
        int exp5[4];

        rst4 = 1'b1; en4 = 1'b1; mode4 = 1'b1; ack4 = 1'b1; y4 = 4'b1111;
        rst5 = 1'b1; en5 = 1'b1; mode5 = 1'b1; ack5 = 1'b1; y5 = 5'b10001;

        //   rst en mode ack  Y         valid A  multi
        // Reset held with requests active, then round-robin from ptr=0.
        add(1, 1, 1, 1, 4'b1111,   0, 0, 0);
        add(1, 1, 1, 1, 4'b1111,   0, 0, 0);
        add(0, 1, 1, 1, 4'b1111,   1, 0, 1);
        add(0, 1, 1, 1, 4'b1111,   1, 1, 1);
        add(0, 1, 1, 1, 4'b1111,   1, 2, 1);
        add(0, 1, 1, 1, 4'b1111,   1, 3, 1);
        add(0, 1, 1, 1, 4'b1111,   1, 0, 1);
        add(0, 1, 1, 1, 4'b1111,   1, 1, 1);
        // Fixed priority, highest index wins.
        add(0, 1, 0, 1, 4'b1000,   1, 3, 0);
        add(0, 1, 0, 1, 4'b0110,   1, 2, 1);
        add(0, 1, 0, 1, 4'b0000,   0, 2, 0);
        // Hold: result frozen while ack=0, en=0 does not cancel it.
        add(0, 1, 0, 1, 4'b0001,   1, 0, 0);
        add(0, 0, 0, 0, 4'b1000,   1, 0, 0);
        add(0, 0, 0, 0, 4'b1000,   1, 0, 0);
        add(0, 0, 0, 0, 4'b1000,   1, 0, 0);
        add(0, 1, 0, 1, 4'b1000,   1, 3, 0);
        // Sparse round-robin.
        add(0, 1, 1, 1, 4'b0101,   1, 0, 1);
        add(0, 1, 1, 1, 4'b0101,   1, 2, 1);
        add(0, 1, 1, 1, 4'b0101,   1, 0, 1);
        add(0, 1, 1, 1, 4'b0101,   1, 2, 1);
        // Reset mid-HOLD discards the result and clears the pointer.
        add(0, 0, 1, 0, 4'b0000,   1, 2, 1);
        add(1, 1, 1, 0, 4'b1111,   0, 0, 0);
        add(0, 1, 1, 0, 4'b1111,   1, 0, 1);
        // Accept with en=0: output empties but pointer still advances.
        add(0, 0, 1, 1, 4'b1111,   0, 0, 0);
        add(0, 1, 1, 1, 4'b1111,   1, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst4 = vecs[i].rst; en4 = vecs[i].en; mode4 = vecs[i].mode;
            ack4 = vecs[i].ack; y4 = vecs[i].y;
            if (i == 1) rst5 = 1'b0;
            tick();
            chk("valid", i, int'(valid4), int'(vecs[i].valid_e));
            chk("A",     i, int'(a4),     int'(vecs[i].a_e));
            chk("multi", i, int'(multi4), int'(vecs[i].multi_e));
        end

        // N=5 non-power-of-two wrap: pointer goes 4 -> 0.
        rst5 = 1'b1;
        tick();
        chk("n5_rst_valid", 0, int'(valid5), 0);
        chk("n5_rst_A",     0, int'(a5),     0);
        rst5 = 1'b0; mode5 = 1'b1; en5 = 1'b1; ack5 = 1'b1; y5 = 5'b10001;
        exp5[0] = 0; exp5[1] = 4; exp5[2] = 0; exp5[3] = 4;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("n5_valid", i, int'(valid5), 1);
            chk("n5_A",     i, int'(a5),     exp5[i]);
            chk("n5_multi", i, int'(multi5), 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
